// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and elaboration helpers for the parametrised FIFO
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  // Almost-empty must sit strictly below almost-full, and almost-full must be reachable.
  function automatic bit levels_ok(input int ae_level, input int af_level, input int depth);
    return (ae_level < af_level) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// rtl/fifo_mem_2p.sv - DEPTH x DATA_W register file, one synchronous write and one synchronous read port
module fifo_mem_2p #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Same-address read and write in one cycle returns the old word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with occupancy, threshold flags and error pulses
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int AF_LEVEL = DEPTH - 2,
  parameter  int AE_LEVEL = 2,
  localparam int ADDR_W   = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] d_in,
  input  logic              re,
  output logic [DATA_W-1:0] d_out,
  output logic              d_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  if (!levels_ok(AE_LEVEL, AF_LEVEL, DEPTH) || !is_pow2(DEPTH) || DEPTH < 4 || DATA_W < 1)
  begin : g_bad_params
    $error("sync_fifo_param: illegal DATA_W/DEPTH/AE_LEVEL/AF_LEVEL combination");
  end

  localparam logic [ADDR_W:0] AF_THR = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_THR = AE_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE    = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            d_valid_q, overflow_q, underflow_q;
  logic            wr_ok, rd_ok;

  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // A read at full frees the slot the write lands in; a read at empty never falls through.
  assign rd_ok = re & ~empty;
  assign wr_ok = we & (~full | re);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + ONE;
    if (rd_ok) rd_ptr_d = rd_ptr_q + ONE;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      d_valid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      d_valid_q   <= rd_ok;
      overflow_q  <= we & full & ~re;
      underflow_q <= re & empty;
    end
  end

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_ok),
    .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
    .wr_data_i (d_in),
    .rd_en_i   (rd_ok),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o (d_out)
  );

  assign count        = count_q;
  assign almost_full  = (count_q >= AF_THR);
  assign almost_empty = (count_q <= AE_THR);
  assign d_valid      = d_valid_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - randomized bench for sync_fifo_param against a queue-based reference model
module tb_sync_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF     = DEPTH - 2;
  localparam int AE     = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              we = 1'b0;
  logic              re = 1'b0;
  logic [DATA_W-1:0] d_in = '0;
  logic [DATA_W-1:0] d_out;
  logic              d_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]        count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] exp_dout = '0;
  logic              exp_valid = 1'b0;
  logic              exp_ovf = 1'b0;
  logic              exp_unf = 1'b0;
  string             phase = "init";

  sync_fifo_param #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .we           (we),
    .d_in         (d_in),
    .re           (re),
    .d_out        (d_out),
    .d_valid      (d_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    int n;
    n = model_q.size();
    check_eq({phase, ".count"},        32'(count),        32'(n));
    check_eq({phase, ".full"},         32'(full),         32'(n == DEPTH));
    check_eq({phase, ".empty"},        32'(empty),        32'(n == 0));
    check_eq({phase, ".almost_full"},  32'(almost_full),  32'(n >= AF));
    check_eq({phase, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
    check_eq({phase, ".d_valid"},      32'(d_valid),      32'(exp_valid));
    check_eq({phase, ".d_out"},        32'(d_out),        32'(exp_dout));
    check_eq({phase, ".overflow"},     32'(overflow),     32'(exp_ovf));
    check_eq({phase, ".underflow"},    32'(underflow),    32'(exp_unf));
  endtask

  // One clock of stimulus; the model decides acceptance from its own occupancy.
  task automatic step(input bit w, input bit r, input logic [DATA_W-1:0] d);
    int n;
    we   = w;
    re   = r;
    d_in = d;
    n = model_q.size();
    exp_ovf   = w && (n == DEPTH) && !r;
    exp_unf   = r && (n == 0);
    exp_valid = r && (n > 0);
    if (exp_valid) exp_dout = model_q.pop_front();
    if (w && ((n < DEPTH) || r)) model_q.push_back(d);
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic async_reset_check();
    we = 1'b0;
    re = 1'b0;
    #2 rst = 1'b0;
    model_q.delete();
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
    #1;
    check_state();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    phase = "reset";
    #3 rst = 1'b0;
    model_q.delete();
    #1;
    check_state();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    phase = "fill";
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, DATA_W'(i));
    phase = "overflow";
    step(1'b1, 1'b0, 8'hFF);
    step(1'b0, 1'b0, 8'h00);

    phase = "drain";
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);
    phase = "underflow";
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    phase = "full_rw";
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DATA_W'($urandom));
    step(1'b1, 1'b1, 8'hAA);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);

    phase = "empty_rw";
    step(1'b1, 1'b1, 8'h55);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    phase = "random";
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, DATA_W'($urandom));
    end

    phase = "midstream_rst";
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DATA_W'($urandom));
    async_reset_check();
    phase = "post_rst";
    step(1'b1, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's 16x8 FIFO. Width and depth are configurable.
- Adds occupancy count, programmable almost-full/almost-empty flags, overflow/underflow error pulses, read-data valid, and defined simultaneous read/write at full/empty.
- Sits between producer and consumer blocks in the same clock domain; registered read data (1-cycle latency).

Parameters:
- DATA_W, 8, data width in bits (>=1)
- DEPTH, 16, number of entries; power of two, >=4
- AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL
- ADDR_W (localparam), log2(DEPTH), memory address width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (assert at any time, deassert synchronously to clk)
- we  in  1  write request
- d_in  in  DATA_W  write data
- re  in  1  read request
- d_out  out  DATA_W  read data, registered
- d_valid  out  1  d_out holds newly read word this cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  ADDR_W+1  current occupancy 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

Behaviour:
- Pointers wr_ptr/rd_ptr are ADDR_W+1 bits. The low ADDR_W bits address memory; the MSB is a wrap bit. Wrap is natural modulo 2*DEPTH.
- full = (ptr MSBs differ, low bits equal); empty = (ptrs equal). Flags are combinational from registered pointers/count only.
- rd_ok = re & ~empty.
- wr_ok = we & (~full | re). When full, a simultaneous read frees a slot, so both are accepted.
- When empty, re & we: write accepted, read rejected (no fall-through).
- overflow = we & full & ~re. underflow = re & empty. Both registered, asserted exactly one cycle after the offending request.
- On wr_ok: mem[wr_ptr] <= d_in; wr_ptr++.
- On rd_ok: d_out <= mem[rd_ptr]; rd_ptr++; d_valid <= 1.
- Without rd_ok: d_valid <= 0 and d_out holds its last value.
- count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither. It is a registered counter and must always equal wr_ptr - rd_ptr.
- Read latency: word is presented on d_out with d_valid in the cycle after the accepted re.
- Write-to-empty-deassert: 1 cycle. A word written in cycle N is readable by re in cycle N+1.
- Reset (rst=0, async, any time including mid-burst):
  - wr_ptr=0, rd_ptr=0, count=0
  - d_out=0, d_valid=0, overflow=0, underflow=0
  - Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0
  - Memory contents are not reset and are don't-care.
- Rejected requests never modify pointers, count or memory.
- Data order is strictly first-in first-out across any number of wraps.

Decomposition:
- Shared package fifo_pkg holds:
  - default DATA_W/DEPTH constants
  - a clog2 constant function
  - the threshold-legality check (AE_LEVEL < AF_LEVEL <= DEPTH)
- One sub-module: fifo_mem_2p, a DEPTH x DATA_W register file with one synchronous write port and one synchronous read port. No reset on storage.
- Pointer, count, flag and error logic stays in sync_fifo_param.

Test Plan:
- Reset: drive rst=0 mid-cycle -> immediately count=0, empty=1, almost_empty=1, full=0, d_valid=0, d_out=0.
- Fill, then overflow (DATA_W=8, DEPTH=16):
  - Write 0x01..0x10 on consecutive cycles -> almost_full rises after the 14th write, full=1 and count=16 after the 16th.
  - A 17th write of 0xFF -> overflow pulses one cycle, count stays 16, 0xFF is never read out.
- Drain, then underflow:
  - Assert re for 16 cycles -> d_out = 0x01..0x10 in order, each one cycle after its re, d_valid=1 throughout; empty=1 after the last read.
  - A 17th re -> underflow pulse, d_valid=0, d_out holds 0x10.
- Full with simultaneous re & we: with FIFO full, we+re with d_in=0xAA -> d_out=oldest word, count stays 16, no overflow; 0xAA emerges after the 15 remaining words.
- Empty with simultaneous re & we: with FIFO empty, we+re with d_in=0x55 -> underflow pulse, count=1; next-cycle re returns 0x55.
- Wrap and async reset: stream 40 words with random re/we -> scoreboard order matches and count always equals the model. Then assert rst mid-stream -> all state clears, and the first post-reset write/read returns only new data.
